// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-stage enables and bubble strobes for load-use, jump and branch hazards.
// Optional run/halt/single-step debug FSM is compiled in with `define DEBUG_STEP_EN.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             debug_en,
    input  logic             step,
    input  logic             clr_cnt,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_jump,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_wb_addr,
    input  logic             ex_branch_taken,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             id_flush,
    output logic             ex_flush,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10
    } dbg_state_t;

    logic advance;
    logic lu;
    logic br_taken;
    logic stall_sel;

`ifdef DEBUG_STEP_EN
    dbg_state_t state;
    dbg_state_t state_next;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_RUN:  if (debug_en) state_next = ST_HALT;
            ST_HALT: begin
                if (!debug_en)  state_next = ST_RUN;
                else if (step)  state_next = ST_STEP;
            end
            ST_STEP: state_next = debug_en ? ST_HALT : ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    assign advance   = !rst && (state == ST_RUN || state == ST_STEP);
    assign dbg_state = state;
`else
    logic unused_dbg;
    assign unused_dbg = debug_en ^ step;
    assign advance    = !rst;
    assign dbg_state  = 2'b00;
`endif

    // A load in EX whose destination is read by the ID instruction cannot be forwarded in time.
    assign lu = ex_valid && ex_mem_read && (ex_wb_addr != 5'd0) &&
                ((id_rs_used && (id_rs_addr == ex_wb_addr)) ||
                 (id_rt_used && (id_rt_addr == ex_wb_addr)));

    assign br_taken  = ex_valid && ex_branch_taken;
    assign stall_sel = advance && !br_taken && lu;

    always_comb begin
        if_en    = 1'b0;
        id_en    = 1'b0;
        ex_en    = 1'b0;
        mem_en   = 1'b0;
        wb_en    = 1'b0;
        id_flush = 1'b0;
        ex_flush = 1'b0;
        if (advance) begin
            if_en  = 1'b1;
            id_en  = 1'b1;
            ex_en  = 1'b1;
            mem_en = 1'b1;
            wb_en  = 1'b1;
            if (br_taken) begin
                id_flush = 1'b1;
                ex_flush = 1'b1;
            end else if (lu) begin
                // Hold PC and IF/ID so the consumer (and any jump it carries) is re-presented.
                if_en    = 1'b0;
                id_en    = 1'b0;
                ex_flush = 1'b1;
            end else if (id_jump) begin
                id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (advance) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (stall_sel && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((id_flush || ex_flush) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl with a scoreboard queue of expected hazard outputs
// and a small saturating counter model; narrow counters keep the wrap/saturation cases short.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             rst, debug_en, step, clr_cnt;
    logic [4:0]       id_rs_addr, id_rt_addr, ex_wb_addr;
    logic             id_rs_used, id_rt_used, id_jump, ex_valid, ex_mem_read, ex_branch_taken;
    logic             if_en, id_en, ex_en, mem_en, wb_en, id_flush, ex_flush;
    logic [1:0]       dbg_state;
    logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .debug_en(debug_en), .step(step), .clr_cnt(clr_cnt),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_jump(id_jump),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_wb_addr(ex_wb_addr),
        .ex_branch_taken(ex_branch_taken),
        .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
        .id_flush(id_flush), .ex_flush(ex_flush), .dbg_state(dbg_state),
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, dbg, stp, clr;
        logic [4:0] rs;
        logic       rs_used;
        logic [4:0] rt;
        logic       rt_used, jump, valid, mem_read;
        logic [4:0] wb;
        logic       br;
        logic [1:0] st;
        logic [4:0] en;
        logic       id_fl, ex_fl;
    } vec_t;

    typedef struct packed {
        logic [1:0] st;
        logic [4:0] en;
        logic       id_fl;
        logic       ex_fl;
    } exp_t;

    localparam logic [4:0] EN_ALL   = 5'b11111;
    localparam logic [4:0] EN_STALL = 5'b00111;
    localparam logic [4:0] EN_NONE  = 5'b00000;

    vec_t             vecs[$];
    exp_t             sb[$];
    logic [CNT_W-1:0] m_cyc, m_stall, m_flush;
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic r, d, s, c,
                                input logic [4:0] rs, input logic rsu,
                                input logic [4:0] rt, input logic rtu,
                                input logic j, v, mr, input logic [4:0] wb, input logic b,
                                input logic [1:0] st, input logic [4:0] en, input logic idf, exf);
        vec_t x;
        x.rst = r; x.dbg = d; x.stp = s; x.clr = c;
        x.rs = rs; x.rs_used = rsu; x.rt = rt; x.rt_used = rtu;
        x.jump = j; x.valid = v; x.mem_read = mr; x.wb = wb; x.br = b;
        x.st = st; x.en = en; x.id_fl = idf; x.ex_fl = exf;
        return x;
    endfunction

    // Common shapes: quiet cycle, load-use on rs=8, and a plain debug row.
    function automatic vec_t quiet(input logic d, s, input logic [1:0] st, input logic [4:0] en);
        return mk(0, d, s, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0, st, en, 0, 0);
    endfunction

    function automatic vec_t lu8(input logic d, c, input logic [1:0] st, input logic [4:0] en,
                                 input logic exf);
        return mk(0, d, 0, c, 5'd8, 1, 5'd0, 0, 0, 1, 1, 5'd8, 0, st, en, 0, exf);
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; debug_en = v.dbg; step = v.stp; clr_cnt = v.clr;
        id_rs_addr = v.rs; id_rs_used = v.rs_used; id_rt_addr = v.rt; id_rt_used = v.rt_used;
        id_jump = v.jump; ex_valid = v.valid; ex_mem_read = v.mem_read; ex_wb_addr = v.wb;
        ex_branch_taken = v.br;
        sb.push_back('{st: v.st, en: v.en, id_fl: v.id_fl, ex_fl: v.ex_fl});
        #1;
        e = sb.pop_front();
        check("hazard_out {st,en,idf,exf}",
              32'({dbg_state, if_en, id_en, ex_en, mem_en, wb_en, id_flush, ex_flush}), 32'(e));
        @(posedge clk);
        #1;
        if (v.rst || v.clr) begin
            m_cyc = '0; m_stall = '0; m_flush = '0;
        end else if (e.en != EN_NONE) begin
            m_cyc = m_cyc + 1'b1;
            if (e.en == EN_STALL && m_stall != CNT_MAX) m_stall = m_stall + 1'b1;
            if ((e.id_fl || e.ex_fl) && m_flush != CNT_MAX) m_flush = m_flush + 1'b1;
        end
        check("cyc_cnt", 32'(cyc_cnt), 32'(m_cyc));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_cyc = '0; m_stall = '0; m_flush = '0;
        rst = 1'b1; debug_en = 0; step = 0; clr_cnt = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_rs_used = 0; id_rt_used = 0; id_jump = 0;
        ex_valid = 0; ex_mem_read = 0; ex_wb_addr = 0; ex_branch_taken = 0;
        repeat (2) @(posedge clk);

        //         rst dbg stp clr rs  rsu rt  rtu  j  v mr wb  br  st     en        idf exf
        vecs.push_back(mk(1, 0, 0, 0, 5'd8, 1, 5'd0, 0, 1, 1, 1, 5'd8, 0, 2'b00, EN_NONE, 0, 0));
        vecs.push_back(quiet(0, 0, 2'b00, EN_ALL));
        vecs.push_back(lu8(0, 0, 2'b00, EN_STALL, 1));
        vecs.push_back(mk(0, 0, 0, 0, 5'd8, 1, 5'd0, 0, 0, 0, 1, 5'd8, 0, 2'b00, EN_ALL, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5'd0, 1, 5'd0, 1, 0, 1, 1, 5'd0, 0, 2'b00, EN_ALL, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5'd8, 0, 5'd3, 1, 0, 1, 1, 5'd8, 0, 2'b00, EN_ALL, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5'd1, 1, 5'd9, 1, 0, 1, 1, 5'd9, 0, 2'b00, EN_STALL, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 5'd1, 1, 5'd9, 0, 0, 1, 1, 5'd9, 0, 2'b00, EN_ALL, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5'd8, 1, 5'd0, 0, 0, 1, 0, 5'd8, 0, 2'b00, EN_ALL, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 5'd0, 0, 2'b00, EN_ALL, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5'd8, 1, 5'd0, 0, 1, 1, 1, 5'd8, 0, 2'b00, EN_STALL, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 5'd8, 1, 5'd0, 0, 1, 0, 1, 5'd8, 0, 2'b00, EN_ALL, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 5'd8, 1, 5'd8, 1, 1, 1, 1, 5'd8, 1, 2'b00, EN_ALL, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 2'b00, EN_ALL, 0, 0));
        vecs.push_back(lu8(0, 1, 2'b00, EN_STALL, 1));

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
        check("clr_over_incr stall_cnt", 32'(stall_cnt), 32'd0);

        // Counter saturation and cycle wrap: 17 back-to-back stalls from zero.
        for (int i = 0; i < 17; i++) run_vec(lu8(0, 0, 2'b00, EN_STALL, 1));
        check("stall_cnt saturated", 32'(stall_cnt), 32'(CNT_MAX));
        check("cyc_cnt wrapped", 32'(cyc_cnt), 32'd1);

`ifdef DEBUG_STEP_EN
        run_vec(mk(0, 0, 0, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 2'b00, EN_ALL, 0, 0));
        run_vec(quiet(1, 0, 2'b00, EN_ALL));
        run_vec(quiet(1, 0, 2'b01, EN_NONE));
        run_vec(quiet(1, 1, 2'b01, EN_NONE));
        run_vec(quiet(1, 1, 2'b10, EN_ALL));
        run_vec(quiet(1, 0, 2'b01, EN_NONE));
        check("debug cyc_cnt", 32'(cyc_cnt), 32'd2);
        // Load-use inside a step consumes it; the next step lets the consumer through.
        run_vec(quiet(1, 1, 2'b01, EN_NONE));
        run_vec(lu8(1, 0, 2'b10, EN_STALL, 1));
        run_vec(mk(0, 1, 0, 0, 5'd8, 1, 5'd0, 0, 0, 0, 1, 5'd8, 0, 2'b01, EN_NONE, 0, 0));
        run_vec(mk(0, 1, 1, 0, 5'd8, 1, 5'd0, 0, 0, 0, 1, 5'd8, 0, 2'b01, EN_NONE, 0, 0));
        run_vec(mk(0, 1, 0, 0, 5'd8, 1, 5'd0, 0, 0, 0, 1, 5'd8, 0, 2'b10, EN_ALL, 0, 0));
        // Reset while in STEP returns to RUN without touching the counters beyond clearing.
        run_vec(quiet(1, 1, 2'b01, EN_NONE));
        run_vec(mk(1, 1, 1, 0, 5'd8, 1, 5'd0, 0, 0, 1, 1, 5'd8, 0, 2'b10, EN_NONE, 0, 0));
        run_vec(quiet(1, 0, 2'b00, EN_ALL));
        run_vec(quiet(0, 0, 2'b01, EN_NONE));
        run_vec(quiet(0, 0, 2'b00, EN_ALL));
`else
        for (int i = 0; i < 4; i++) run_vec(quiet(1, i[0], 2'b00, EN_ALL));
        run_vec(lu8(1, 0, 2'b00, EN_STALL, 1));
`endif

        // Reset mid-stream: enables drop and counters clear, then normal advance resumes.
        run_vec(mk(1, 0, 0, 0, 5'd8, 1, 5'd0, 0, 1, 1, 1, 5'd8, 1, 2'b00, EN_NONE, 0, 0));
        check("rst cyc_cnt", 32'(cyc_cnt), 32'd0);
        run_vec(quiet(0, 0, 2'b00, EN_ALL));
        run_vec(lu8(0, 0, 2'b00, EN_STALL, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
